// File: rtl/wta_spike_select.sv
// ---------------------------------------------------------------------------
// wta_spike_select
//
// Winner-take-all spike selector that sits behind the 2-input potential
// comparator of the neuron layer. An accepted input event starts a short
// settle wait so that the comparator outputs are stable. The block then makes
// a single-cycle decision: the comparator's winner fires only if its potential
// reaches that neuron's adaptive threshold. The decision drives a registered
// one-cycle spike/valid pulse and adapts the thresholds. A refractory period
// follows the decision. Events that arrive while the block is busy are counted
// as drops and are otherwise ignored.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_event     input-event strobe, accepted only while idle
//   i_result    comparator winning potential
//   i_index     comparator index: 00 none, 01 neuron0, 10 neuron1
//   o_valid     one-cycle pulse marking a completed decision
//   o_spike     one-hot spike, qualified by o_valid
//   o_winner    winner index (00 = none), qualified by o_valid
//   o_busy      high whenever the block is not idle
//   o_th0       current neuron0 threshold
//   o_th1       current neuron1 threshold
//   o_drop_cnt  saturating count of events dropped while busy
// ---------------------------------------------------------------------------
module wta_spike_select #(
    parameter int P_WIDTH     = 21,
    parameter int P_SETTLE    = 1,
    parameter int P_REFRACT   = 4,
    parameter int P_TH_INIT   = 1000,
    parameter int P_TH_STEP   = 8,
    parameter int P_TH_MIN    = 16,
    parameter int P_ETA_SHIFT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_event,
    input  logic [P_WIDTH-1:0] i_result,
    input  logic [1:0]         i_index,
    output logic               o_valid,
    output logic [1:0]         o_spike,
    output logic [1:0]         o_winner,
    output logic               o_busy,
    output logic [P_WIDTH-1:0] o_th0,
    output logic [P_WIDTH-1:0] o_th1,
    output logic [7:0]         o_drop_cnt
);

    // One down-counter serves both the settle wait and the refractory wait,
    // so it is sized for the larger of the two.
    localparam int CNT_MAX = (P_SETTLE > P_REFRACT) ? P_SETTLE : P_REFRACT;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SETTLE_LOAD  = CNT_W'(P_SETTLE);
    localparam logic [CNT_W-1:0]   REFRACT_LOAD = CNT_W'(P_REFRACT);
    localparam logic               HAS_REFRACT  = (P_REFRACT > 0);
    localparam logic [P_WIDTH-1:0] TH_INIT      = P_WIDTH'(P_TH_INIT);
    localparam logic [P_WIDTH-1:0] TH_STEP      = P_WIDTH'(P_TH_STEP);
    localparam logic [P_WIDTH-1:0] TH_MIN       = P_WIDTH'(P_TH_MIN);
    localparam logic [P_WIDTH-1:0] TH_DECAY_LIM = P_WIDTH'(P_TH_MIN + P_TH_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_REFRACT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [1:0]         spike_q, spike_d;
    logic [P_WIDTH-1:0] th0_q, th0_d;
    logic [P_WIDTH-1:0] th1_q, th1_d;
    logic [7:0]         drop_q, drop_d;

    logic               deciding;
    logic               win0;
    logic               win1;

    // A decayed threshold never drops below the floor.
    function automatic logic [P_WIDTH-1:0] decay(input logic [P_WIDTH-1:0] th);
        decay = (th < TH_DECAY_LIM) ? TH_MIN : (th - TH_STEP);
    endfunction

    // Moves a winning threshold a fraction of the way toward the winning
    // potential; the caller guarantees pot >= th, so the difference is unsigned.
    function automatic logic [P_WIDTH-1:0] adapt(input logic [P_WIDTH-1:0] th,
                                                 input logic [P_WIDTH-1:0] pot);
        adapt = th + ((pot - th) >> P_ETA_SHIFT);
    endfunction

    // Next-state logic. The settle wait lasts P_SETTLE+1 cycles because the
    // comparator index is registered on the falling edge and needs the extra
    // cycle to reach a stable value here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_event) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DECIDE: begin
                if (HAS_REFRACT) begin
                    state_d = S_REFRACT;
                    cnt_d   = REFRACT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REFRACT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decision, threshold adaptation and drop counting. Index 11 matches
    // neither neuron and is therefore treated as no winner.
    always_comb begin
        deciding = (state_q == S_DECIDE);
        win0     = deciding && (i_index == 2'b01) && (i_result >= th0_q);
        win1     = deciding && (i_index == 2'b10) && (i_result >= th1_q);

        valid_d  = deciding;
        spike_d  = {win1, win0};
        th0_d    = th0_q;
        th1_d    = th1_q;
        drop_d   = drop_q;

        if (deciding) begin
            if (win0) begin
                th0_d = adapt(th0_q, i_result);
            end else if (win1) begin
                th1_d = adapt(th1_q, i_result);
            end else begin
                th0_d = decay(th0_q);
                th1_d = decay(th1_q);
            end
        end

        if (i_event && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State and output registers; a reset mid-decision discards it entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            spike_q <= 2'b00;
            th0_q   <= TH_INIT;
            th1_q   <= TH_INIT;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            spike_q <= spike_d;
            th0_q   <= th0_d;
            th1_q   <= th1_d;
            drop_q  <= drop_d;
        end
    end

    // The one-hot spike doubles as the winner index: 01 = neuron0, 10 = neuron1.
    assign o_valid    = valid_q;
    assign o_spike    = spike_q;
    assign o_winner   = spike_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_th0      = th0_q;
    assign o_th1      = th1_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_wta_spike_select.sv
// ---------------------------------------------------------------------------
// tb_wta_spike_select
//
// Self-checking bench for wta_spike_select: reset values, a table of single
// decisions from reset, latency/busy timing, threshold floor, drop
// saturation, reset during a decision and a randomized run against a
// behavioural model of the thresholds and drop counter.
// ---------------------------------------------------------------------------
module tb_wta_spike_select;

    localparam int PS       = 1;
    localparam int PR       = 4;
    localparam int TH_INIT  = 1000;
    localparam int TH_STEP  = 8;
    localparam int TH_MIN   = 16;
    localparam int ETA_DIV  = 4;
    localparam int BUSY_LEN = (PS + 1) + 1 + PR;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev;
    logic [20:0] result;
    logic [1:0]  index;
    logic        o_valid;
    logic [1:0]  o_spike;
    logic [1:0]  o_winner;
    logic        o_busy;
    logic [20:0] o_th0;
    logic [20:0] o_th1;
    logic [7:0]  o_drop_cnt;

    int total = 0;
    int bad   = 0;
    int mTh0, mTh1, mDrop;
    int seenSpike, seenWinner;

    typedef struct {
        int res;
        int idx;
        int spike;
        int th0;
        int th1;
    } vec_t;

    vec_t vecs[8];

    wta_spike_select dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_event    (ev),
        .i_result   (result),
        .i_index    (index),
        .o_valid    (o_valid),
        .o_spike    (o_spike),
        .o_winner   (o_winner),
        .o_busy     (o_busy),
        .o_th0      (o_th0),
        .o_th1      (o_th1),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        ev     = 1'b0;
        result = '0;
        index  = 2'b00;
        tick();
        tick();
        rst_n  = 1'b1;
        mTh0   = TH_INIT;
        mTh1   = TH_INIT;
        mDrop  = 0;
    endtask

    // Reference decision: winner must match the index and reach its threshold;
    // a winner moves a quarter of the way to its potential, otherwise both decay.
    task automatic modelDecide(input int res, input int idx, output int spike);
        int w;
        w = 0;
        if (idx == 1 && res >= mTh0) w = 1;
        if (idx == 2 && res >= mTh1) w = 2;
        spike = w;
        if (w == 1) begin
            mTh0 = mTh0 + (res - mTh0) / ETA_DIV;
        end else if (w == 2) begin
            mTh1 = mTh1 + (res - mTh1) / ETA_DIV;
        end else begin
            mTh0 = (mTh0 - TH_STEP > TH_MIN) ? mTh0 - TH_STEP : TH_MIN;
            mTh1 = (mTh1 - TH_STEP > TH_MIN) ? mTh1 - TH_STEP : TH_MIN;
        end
    endtask

    // One full decision from idle; optional noise events during the busy window.
    task automatic applyStimulus(input int res, input int idx, input bit noisy);
        int expSpike;
        result = 21'(res);
        index  = 2'(idx);
        ev     = 1'b1;
        tick();
        modelDecide(res, idx, expSpike);
        for (int n = 1; n <= BUSY_LEN; n++) begin
            ev = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ev && mDrop < 255) mDrop++;
            tick();
            if (n == PS + 2) begin
                checkOutput("valid_pulse", o_valid, 1);
                checkOutput("spike", o_spike, expSpike);
                checkOutput("winner", o_winner, expSpike);
                checkOutput("th0_after", o_th0, mTh0);
                checkOutput("th1_after", o_th1, mTh1);
                seenSpike  = o_spike;
                seenWinner = o_winner;
            end else begin
                checkOutput("valid_idle", o_valid, 0);
            end
            if (n == BUSY_LEN - 1) checkOutput("busy_refract", o_busy, 1);
        end
        ev = 1'b0;
        checkOutput("busy_done", o_busy, 0);
        checkOutput("drop_cnt", o_drop_cnt, mDrop);
    endtask

    initial begin
        int accepted, drops, nextFree, valids, r, base, idx;

        vecs[0] = '{1200, 1, 1, 1050, 1000};
        vecs[1] = '{ 900, 2, 0,  992,  992};
        vecs[2] = '{1000, 1, 1, 1000, 1000};
        vecs[3] = '{ 999, 1, 0,  992,  992};
        vecs[4] = '{2000, 2, 2, 1000, 1250};
        vecs[5] = '{5000, 3, 0,  992,  992};
        vecs[6] = '{1003, 2, 2, 1000, 1000};
        vecs[7] = '{   0, 0, 0,  992,  992};

        // Reset values
        doReset();
        checkOutput("rst_th0", o_th0, 1000);
        checkOutput("rst_th1", o_th1, 1000);
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_spike", o_spike, 0);
        checkOutput("rst_winner", o_winner, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_drop", o_drop_cnt, 0);

        // Table of single decisions, each from reset
        for (int i = 0; i < 8; i++) begin
            doReset();
            applyStimulus(vecs[i].res, vecs[i].idx, 1'b0);
            checkOutput("tbl_spike", seenSpike, vecs[i].spike);
            checkOutput("tbl_winner", seenWinner, vecs[i].spike);
            checkOutput("tbl_th0", o_th0, vecs[i].th0);
            checkOutput("tbl_th1", o_th1, vecs[i].th1);
        end

        // Threshold floor: 123 decays reach 16, further decays hold it
        doReset();
        for (int i = 0; i < 126; i++) begin
            applyStimulus(0, 0, 1'b0);
        end
        checkOutput("floor_th0", o_th0, 16);
        checkOutput("floor_th1", o_th1, 16);

        // Event on every edge: only idle-accepted events decide, drops saturate
        doReset();
        accepted = 0;
        drops    = 0;
        nextFree = 0;
        for (int e = 0; e < 600; e++) begin
            if (e >= nextFree) begin
                accepted++;
                nextFree = e + BUSY_LEN + 1;
            end else begin
                drops++;
            end
        end
        valids = 0;
        index  = 2'b00;
        result = '0;
        ev     = 1'b1;
        for (int e = 0; e < 600; e++) begin
            tick();
            if (o_valid) valids++;
        end
        ev = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (o_valid) valids++;
        end
        checkOutput("flood_valids", valids, accepted);
        checkOutput("flood_drop_sat", o_drop_cnt, (drops > 255) ? 255 : drops);

        // Reset asserted while the winning decision is being made
        doReset();
        result = 21'd1200;
        index  = 2'b01;
        ev     = 1'b1;
        tick();
        ev = 1'b0;
        for (int n = 0; n < PS + 1; n++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", o_valid, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_th0", o_th0, 1000);
        tick();
        rst_n = 1'b1;
        valids = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (o_valid) valids++;
        end
        checkOutput("abort_no_valid", valids, 0);
        checkOutput("abort_th0_hold", o_th0, 1000);
        checkOutput("abort_th1_hold", o_th1, 1000);
        checkOutput("abort_idle", o_busy, 0);

        // Randomized decisions with noise events against the model
        doReset();
        for (int i = 0; i < 80; i++) begin
            idx  = int'($urandom_range(0, 3));
            base = (idx == 2) ? mTh1 : mTh0;
            r    = base + int'($urandom_range(0, 400)) - 200;
            if (r < 0) r = 0;
            applyStimulus(r, idx, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
